// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: pin synchronisation and deglitching, 11-bit
// device-to-host frame checking, and a first-word-fall-through scan-code
// FIFO presented as a 32-bit stb/ack stream.
module ps2_keyboard_rx #(
   parameter int unsigned FILTER_LEN = 8,
   parameter int unsigned TIMEOUT    = 200000,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic [31:0] output_ps2,
   output logic        output_ps2_stb,
   input  logic        output_ps2_ack,
   output logic        frame_error,
   output logic        overflow
);

   localparam int unsigned FW = $clog2(FILTER_LEN + 1);
   localparam int unsigned TW = $clog2(TIMEOUT);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);

   localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
   localparam logic [FW-1:0] FILT_ONE  = FW'(1);
   // Matching on the value the counter is about to take makes the pulse
   // appear exactly TIMEOUT cycles after the last edge cycle.
   localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 2);
   localparam logic [TW-1:0] TO_ONE    = TW'(1);
   localparam logic [AW:0]   PTR_ONE   = (AW + 1)'(1);

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } state_t;

   // Bit 0 carries ps2_clk, bit 1 carries ps2_data.
   logic [1:0]         pin_s1;
   logic [1:0]         pin_s2;
   logic [1:0]         pin_filt;
   logic [1:0][FW-1:0] filt_cnt;
   logic               clk_filt_q;

   logic               ps2_edge;
   logic               data_bit;

   state_t             state;
   logic [2:0]         bit_cnt;
   logic [7:0]         shreg;
   logic               parity_bit;
   logic [TW-1:0]      to_cnt;
   logic               frame_ok;
   logic               push;

   logic [AW:0]        wr_ptr;
   logic [AW:0]        rd_ptr;
   logic [7:0]         mem [FIFO_DEPTH];
   logic               empty;
   logic               full;
   logic               pop;
   logic               do_write;

   // Two-stage synchronisers followed by a run-length filter per pin.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pin_s1     <= '1;
         pin_s2     <= '1;
         pin_filt   <= '1;
         filt_cnt   <= '0;
         clk_filt_q <= 1'b1;
      end else begin
         pin_s1     <= {ps2_data, ps2_clk};
         pin_s2     <= pin_s1;
         clk_filt_q <= pin_filt[0];
         for (int unsigned i = 0; i < 2; i++) begin
            if (pin_s2[i] == pin_filt[i]) begin
               filt_cnt[i] <= '0;
            end else if (filt_cnt[i] == FILT_LAST) begin
               pin_filt[i] <= pin_s2[i];
               filt_cnt[i] <= '0;
            end else begin
               filt_cnt[i] <= filt_cnt[i] + FILT_ONE;
            end
         end
      end
   end

   assign ps2_edge = clk_filt_q & ~pin_filt[0];
   assign data_bit = pin_filt[1];

   assign frame_ok = data_bit & (^shreg ^ parity_bit);
   assign push     = ps2_edge && (state == STOP) && frame_ok;

   // Frame receiver: advances on filtered clock falls, aborts on inactivity.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         bit_cnt     <= '0;
         shreg       <= '0;
         parity_bit  <= 1'b0;
         to_cnt      <= '0;
         frame_error <= 1'b0;
      end else begin
         frame_error <= 1'b0;
         if (state == IDLE) begin
            to_cnt <= '0;
            if (ps2_edge) begin
               if (!data_bit) begin
                  state   <= DATA;
                  bit_cnt <= '0;
               end else begin
                  frame_error <= 1'b1;
               end
            end
         end else if (ps2_edge) begin
            to_cnt <= '0;
            case (state)
               DATA: begin
                  shreg   <= {data_bit, shreg[7:1]};
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     state <= PARITY;
                  end
               end
               PARITY: begin
                  parity_bit <= data_bit;
                  state      <= STOP;
               end
               default: begin
                  if (!frame_ok) begin
                     frame_error <= 1'b1;
                  end
                  state <= IDLE;
               end
            endcase
         end else if (to_cnt == TO_LAST) begin
            frame_error <= 1'b1;
            state       <= IDLE;
            to_cnt      <= '0;
         end else begin
            to_cnt <= to_cnt + TO_ONE;
         end
      end
   end

   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop      = !empty && output_ps2_ack;
   assign do_write = push && (!full || pop);

   // FIFO pointers and the overflow pulse for bytes dropped while full.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
      end else begin
         overflow <= push && full && !pop;
         if (do_write) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
      end
   end

   // Scan-code storage; when full with a simultaneous pop the write lands in
   // the slot being vacated, which is safe because the head is read first.
   always_ff @(posedge clk) begin
      if (do_write) begin
         mem[wr_ptr[AW-1:0]] <= shreg;
      end
   end

   assign output_ps2_stb = !empty;
   assign output_ps2     = empty ? '0 : {24'd0, mem[rd_ptr[AW-1:0]]};

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx: bit-banged PS/2 frames, a scoreboard
// of expected stream words, and pulse counters for frame_error / overflow.
module tb_ps2_keyboard_rx;

   localparam int unsigned FILTER_LEN = 8;
   localparam int unsigned TIMEOUT    = 400;
   localparam int unsigned FIFO_DEPTH = 8;
   localparam int unsigned HALF       = 20;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ps2_clk = 1'b1;
   logic        ps2_data = 1'b1;
   logic        ack = 1'b0;
   logic [31:0] dout;
   logic        stb;
   logic        ferr;
   logic        ovf;

   int checks = 0;
   int errors = 0;
   int fe_count = 0;
   int ovf_count = 0;
   int xfer_count = 0;
   logic [31:0] sb [$];

   always #5 clk = ~clk;

   ps2_keyboard_rx #(
      .FILTER_LEN (FILTER_LEN),
      .TIMEOUT    (TIMEOUT),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .ps2_clk        (ps2_clk),
      .ps2_data       (ps2_data),
      .output_ps2     (dout),
      .output_ps2_stb (stb),
      .output_ps2_ack (ack),
      .frame_error    (ferr),
      .overflow       (ovf)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Stream monitor: every accepted word is compared with the scoreboard head.
   always @(negedge clk) begin
      logic [31:0] exp_w;
      #2;
      if (ferr === 1'b1) fe_count++;
      if (ovf === 1'b1) ovf_count++;
      if (stb === 1'b1 && ack === 1'b1) begin
         if (sb.size() > 0) exp_w = sb.pop_front();
         else exp_w = 32'hDEAD_BEEF;
         check("xfer_word", dout, exp_w);
         xfer_count++;
      end
   end

   initial begin
      #2_000_000;
      errors++;
      $display("FAIL watchdog simulation did not complete");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic b);
      ps2_data = b;
      wait_cyc(HALF);
      ps2_clk = 1'b0;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
      wait_cyc(HALF);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(par);
      send_bit(stop);
      ps2_data = 1'b1;
   endtask

   // Well-formed frame with odd parity; queue the word only if it should arrive.
   task automatic send_word(input logic [7:0] b, input bit expect_ok);
      if (expect_ok) sb.push_back({24'd0, b});
      send_frame(b, ~^b, 1'b1);
   endtask

   initial begin
      int fe0;
      int k;
      int n;
      bit seen;

      // Reset state
      wait_cyc(3);
      check("rst_dout", dout, 32'd0);
      check("rst_stb", {31'd0, stb}, 32'd0);
      check("rst_ferr", {31'd0, ferr}, 32'd0);
      check("rst_ovf", {31'd0, ovf}, 32'd0);
      rst = 1'b0;
      wait_cyc(5);

      // 1: single valid frame, ack held high
      ack = 1'b1;
      fe0 = fe_count;
      send_word(8'h1C, 1'b1);
      wait_cyc(5);
      check("t1_sb_empty", sb.size(), 32'd0);
      check("t1_xfers", xfer_count, 32'd1);
      check("t1_no_ferr", fe_count, fe0);
      check("t1_no_ovf", ovf_count, 32'd0);

      // 2: parity error
      send_frame(8'h1C, 1'b1, 1'b1);
      wait_cyc(5);
      check("t2_ferr", fe_count, fe0 + 1);
      check("t2_xfers", xfer_count, 32'd1);
      check("t2_stb", {31'd0, stb}, 32'd0);

      // 3: timeout after 5 data bits; 2 sync + FILTER_LEN filter cycles to the edge cycle
      fe0 = fe_count;
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b1);
      ps2_data = 1'b0;
      wait_cyc(HALF);
      ps2_clk = 1'b0;
      k = 0;
      seen = 1'b0;
      while (!seen && k < int'(2 * TIMEOUT + 100)) begin
         @(posedge clk);
         #1;
         k++;
         if (k == int'(HALF)) ps2_clk = 1'b1;
         if (ferr === 1'b1) seen = 1'b1;
      end
      ps2_clk = 1'b1;
      ps2_data = 1'b1;
      check("t3_timeout_latency", k, 2 + FILTER_LEN + TIMEOUT);
      wait_cyc(2);
      check("t3_ferr_count", fe_count, fe0 + 1);
      check("t3_ferr_width", {31'd0, ferr}, 32'd0);
      wait_cyc(HALF);
      send_word(8'h29, 1'b1);
      wait_cyc(5);
      check("t3_sb_empty", sb.size(), 32'd0);
      check("t3_xfers", xfer_count, 32'd2);

      // 4: fill FIFO with ack low, ninth frame overflows, then drain
      ack = 1'b0;
      fe0 = fe_count;
      for (int i = 0; i < 9; i++) send_word(8'hF0, i < 8);
      wait_cyc(5);
      check("t4_ovf_count", ovf_count, 32'd1);
      check("t4_no_ferr", fe_count, fe0);
      check("t4_stb_held", {31'd0, stb}, 32'd1);
      check("t4_head_word", dout, 32'h0000_00F0);
      check("t4_sb_level", sb.size(), 32'd8);
      ack = 1'b1;
      n = 0;
      while (stb === 1'b1 && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("t4_drain_cycles", n, 32'd8);
      wait_cyc(2);
      check("t4_sb_empty", sb.size(), 32'd0);
      check("t4_xfers", xfer_count, 32'd10);
      check("t4_stb_low", {31'd0, stb}, 32'd0);

      // 5: short glitch on ps2_clk while idle
      fe0 = fe_count;
      ps2_clk = 1'b0;
      wait_cyc(3);
      ps2_clk = 1'b1;
      wait_cyc(40);
      check("t5_no_ferr", fe_count, fe0);
      check("t5_stb", {31'd0, stb}, 32'd0);
      send_word(8'h5A, 1'b1);
      wait_cyc(5);
      check("t5_sb_empty", sb.size(), 32'd0);
      check("t5_xfers", xfer_count, 32'd11);

      // 6: reset mid-frame with a word waiting in the FIFO
      ack = 1'b0;
      fe0 = fe_count;
      send_word(8'h1C, 1'b1);
      wait_cyc(5);
      check("t6_word_held", {31'd0, stb}, 32'd1);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      rst = 1'b1;
      #1;
      check("t6_rst_dout", dout, 32'd0);
      check("t6_rst_stb", {31'd0, stb}, 32'd0);
      check("t6_rst_ferr", {31'd0, ferr}, 32'd0);
      check("t6_rst_ovf", {31'd0, ovf}, 32'd0);
      sb.delete();
      ps2_data = 1'b1;
      wait_cyc(3);
      rst = 1'b0;
      ack = 1'b1;
      wait_cyc(5);
      check("t6_no_ferr", fe_count, fe0);
      send_word(8'h1C, 1'b1);
      wait_cyc(5);
      check("t6_sb_empty", sb.size(), 32'd0);
      check("t6_xfers", xfer_count, 32'd12);
      check("t6_stb_low", {31'd0, stb}, 32'd0);
      check("final_ovf_count", ovf_count, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
